// File: rtl/mem_responder_types.sv
// Shared types and helpers for the mem_responder memory slave: FSM state
// encoding, latency counter width and the byte-lane merge used on writes.
package mem_responder_types;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_resp_state_t;

   localparam int MEM_LAT_W = 4;

   function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/mem_bank.sv
// Word array behind mem_responder: synchronous byte-enabled write port and
// an asynchronous read port, kept apart from the FSM so RAM mapping stays simple.
module mem_bank
   import mem_responder_types::*;
#(
   parameter int DEPTH_WORDS = 1024,
   localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [31:0]      wdata,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] raddr,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= be_merge(mem[waddr], wdata, be);
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory slave answering one read/write at a time.
// Optional MEM_RESPONDER_ERRCHK_EN adds a sticky mem_err flag for malformed requests.
//
// state | meaning
// IDLE  | waiting for mem_read|mem_write; latches the request on acceptance
// WAIT  | latency countdown; drops back to IDLE if the request is withdrawn
// RESP  | one-cycle mem_resp; write committed on the edge leaving this state
module mem_responder
   import mem_responder_types::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   output logic        mem_resp,
   output logic [31:0] mem_rdata
`ifdef MEM_RESPONDER_ERRCHK_EN
   ,
   output logic        mem_err
`endif
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [MEM_LAT_W-1:0] LAT_LOAD = MEM_LAT_W'(LATENCY - 1);

   mem_resp_state_t  state;
   logic [MEM_LAT_W-1:0] cnt;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      wdata_q;
   logic [3:0]       be_q;
   logic             op_rd;
   logic             op_wr;

   logic             req;
   logic [IDX_W-1:0] raddr;
   logic [31:0]      bank_rdata;
   logic             bank_we;
   logic             unused_addr;

   assign req         = mem_read | mem_write;
   // In IDLE the read port looks at the live address so LATENCY=1 can answer next cycle.
   assign raddr       = (state == IDLE) ? mem_address[IDX_W+1:2] : idx_q;
   assign bank_we     = (state == RESP) && op_wr;
   assign unused_addr = ^{mem_address[31:IDX_W+2], mem_address[1:0]};

`ifdef MEM_RESPONDER_ERRCHK_EN
   logic req_bad;
   assign req_bad = (mem_read & mem_write)
                  | (mem_write & (mem_byte_enable == 4'b0000))
                  | (|mem_address[31:IDX_W+2]);
`endif

   mem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .waddr (idx_q),
      .wdata (wdata_q),
      .be    (be_q),
      .raddr (raddr),
      .rdata (bank_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx_q     <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         op_rd     <= 1'b0;
         op_wr     <= 1'b0;
         mem_resp  <= 1'b0;
         mem_rdata <= '0;
`ifdef MEM_RESPONDER_ERRCHK_EN
         mem_err   <= 1'b0;
`endif
      end else begin
         mem_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  idx_q   <= mem_address[IDX_W+1:2];
                  wdata_q <= mem_wdata;
                  be_q    <= mem_byte_enable;
                  op_rd   <= mem_read;
                  op_wr   <= mem_write;
                  cnt     <= LAT_LOAD;
`ifdef MEM_RESPONDER_ERRCHK_EN
                  if (req_bad) mem_err <= 1'b1;
`endif
                  if (LATENCY == 1) begin
                     state    <= RESP;
                     mem_resp <= 1'b1;
                     if (mem_read) mem_rdata <= bank_rdata;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!req) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == MEM_LAT_W'(1)) begin
                  state    <= RESP;
                  cnt      <= '0;
                  mem_resp <= 1'b1;
                  // Read+write still returns the word as it was before the write lands.
                  if (op_rd) mem_rdata <= bank_rdata;
               end else begin
                  cnt <= cnt - MEM_LAT_W'(1);
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_RESPONDER_ERRCHK_EN
`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n && (state == IDLE) && req && req_bad)
         $error("mem_responder: malformed request addr=%h rd=%b wr=%b be=%b",
                mem_address, mem_read, mem_write, mem_byte_enable);
   end
`endif
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=3 instance and a small LATENCY=1 instance.
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        rd0, wr0, resp0;
   logic [3:0]  be0;
   logic [31:0] addr0, wdata0, rdata0;
   logic        rd1, wr1, resp1;
   logic [3:0]  be1;
   logic [31:0] addr1, wdata1, rdata1;
`ifdef MEM_RESPONDER_ERRCHK_EN
   logic        err0, err1;
`endif

   int checks   = 0;
   int failures = 0;

   mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_read        (rd0),
      .mem_write       (wr0),
      .mem_byte_enable (be0),
      .mem_address     (addr0),
      .mem_wdata       (wdata0),
      .mem_resp        (resp0),
      .mem_rdata       (rdata0)
`ifdef MEM_RESPONDER_ERRCHK_EN
      ,
      .mem_err         (err0)
`endif
   );

   mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_lat1 (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_read        (rd1),
      .mem_write       (wr1),
      .mem_byte_enable (be1),
      .mem_address     (addr1),
      .mem_wdata       (wdata1),
      .mem_resp        (resp1),
      .mem_rdata       (rdata1)
`ifdef MEM_RESPONDER_ERRCHK_EN
      ,
      .mem_err         (err1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
      if (sel) begin
         rd1 = rd; wr1 = wr; addr1 = addr; wdata1 = wdata; be1 = be;
      end else begin
         rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = wdata; be0 = be;
      end
   endtask

   function automatic logic get_resp(input bit sel);
      return sel ? resp1 : resp0;
   endfunction

   function automatic logic [31:0] get_rdata(input bit sel);
      return sel ? rdata1 : rdata0;
   endfunction

   // Issues one request, measures cycles to mem_resp, then releases and checks the pulse ended.
   task automatic txn(input bit sel, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int exp_lat, input string tag,
                      output logic [31:0] rdata);
      int n;
      n = 0;
      drive(sel, rd, wr, addr, wdata, be);
      for (int k = 1; k <= 20; k++) begin
         step();
         if (get_resp(sel) === 1'b1) begin
            n = k;
            break;
         end
      end
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      rdata = get_rdata(sel);
      drive(sel, 1'b0, 1'b0, addr, wdata, be);
      step();
      chk({tag, "_single_pulse"}, {31'b0, get_resp(sel)}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int pulses;

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) step();
      chk("reset_resp", {31'b0, resp0}, 32'd0);
      chk("reset_rdata", rdata0, 32'h0);
      chk("reset_resp_lat1", {31'b0, resp1}, 32'd0);
      rst_n = 1'b1;
      step();

      // Preload through the interface
      txn(1'b0, 1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 3, "pre14", d);
      chk("write_leaves_rdata", rdata0, 32'h0);
      txn(1'b0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 3, "pre20", d);
      txn(1'b0, 1'b0, 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF, 3, "pre40", d);
      txn(1'b0, 1'b0, 1'b1, 32'h00, 32'h01020304, 4'hF, 3, "pre00", d);
      txn(1'b0, 1'b0, 1'b1, 32'h04, 32'h0A0B0C0D, 4'hF, 3, "pre04", d);
      txn(1'b0, 1'b0, 1'b1, 32'h10, 32'h13579BDF, 4'hF, 3, "pre10", d);

      // Cycle-accurate read of 0x14
      drive(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
      step();
      chk("rd14_c1_resp", {31'b0, resp0}, 32'd0);
      step();
      chk("rd14_c2_resp", {31'b0, resp0}, 32'd0);
      step();
      chk("rd14_c3_resp", {31'b0, resp0}, 32'd1);
      chk("rd14_c3_data", rdata0, 32'hDEADBEEF);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step();
      chk("rd14_c4_resp", {31'b0, resp0}, 32'd0);
      step();
      step();
      chk("rd14_c6_data_held", rdata0, 32'hDEADBEEF);

      // Lane-wise write then read back
      txn(1'b0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'b0110, 3, "wr20_be0110", d);
      txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 3, "rd20", d);
      chk("rd20_data", d, 32'hAA2233DD);

      // Withdrawn write
      drive(1'b0, 1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      pulses = 0;
      repeat (8) begin
         step();
         if (resp0 === 1'b1) pulses++;
      end
      chk("withdraw_no_resp", 32'(pulses), 32'd0);
      txn(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 3, "rd40", d);
      chk("rd40_unchanged", d, 32'h5A5A5A5A);

      // Back-to-back reads with the request held through resp
      drive(1'b0, 1'b1, 1'b0, 32'h00, 32'h0, 4'h0);
      step();
      step();
      step();
      chk("b2b_first_resp", {31'b0, resp0}, 32'd1);
      chk("b2b_first_data", rdata0, 32'h01020304);
      step();
      chk("b2b_c4_resp", {31'b0, resp0}, 32'd0);
      drive(1'b0, 1'b1, 1'b0, 32'h04, 32'h0, 4'h0);
      step();
      chk("b2b_c5_resp", {31'b0, resp0}, 32'd0);
      step();
      chk("b2b_c6_resp", {31'b0, resp0}, 32'd0);
      step();
      chk("b2b_c7_resp", {31'b0, resp0}, 32'd1);
      chk("b2b_second_data", rdata0, 32'h0A0B0C0D);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step();
      chk("b2b_c8_resp", {31'b0, resp0}, 32'd0);

      // Reset during WAIT of a write to 0x10
      drive(1'b0, 1'b0, 1'b1, 32'h10, 32'hFFFF0000, 4'hF);
      step();
      rst_n = 1'b0;
      #1;
      chk("midrst_resp", {31'b0, resp0}, 32'd0);
      chk("midrst_rdata", rdata0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step();
      rst_n = 1'b1;
      step();
      txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 3, "rd10_after_rst", d);
      chk("rd10_unchanged", d, 32'h13579BDF);
`ifdef MEM_RESPONDER_ERRCHK_EN
      chk("err_clear_before", {31'b0, err0}, 32'd0);
`endif

      // Read and write together act as a write returning the old word
      txn(1'b0, 1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 3, "rdwr10", d);
      chk("rdwr10_preword", d, 32'h13579BDF);
      txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 3, "rd10_new", d);
      chk("rd10_new_data", d, 32'hCAFEF00D);
`ifdef MEM_RESPONDER_ERRCHK_EN
      chk("err_set_rdwr", {31'b0, err0}, 32'd1);
`endif

      // Zero byte enables complete without changing the word
      txn(1'b0, 1'b0, 1'b1, 32'h14, 32'h00000000, 4'h0, 3, "wr14_be0", d);
      txn(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 3, "rd14_after_be0", d);
      chk("rd14_after_be0_data", d, 32'hDEADBEEF);
`ifdef MEM_RESPONDER_ERRCHK_EN
      chk("err_sticky", {31'b0, err0}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("err_cleared_by_reset", {31'b0, err0}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
`endif

      // LATENCY=1 instance, 16 words: 0x8 and 0x8+64 hit the same word
      txn(1'b1, 1'b0, 1'b1, 32'h08, 32'h77665544, 4'hF, 1, "l1_wr08", d);
      txn(1'b1, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0, 1, "l1_rd08", d);
      chk("l1_rd08_data", d, 32'h77665544);
      txn(1'b1, 1'b1, 1'b0, 32'h48, 32'h0, 4'h0, 1, "l1_rd48_wrap", d);
      chk("l1_rd48_wrap_data", d, 32'h77665544);
      txn(1'b1, 1'b0, 1'b1, 32'h4C, 32'h99887766, 4'b1000, 1, "l1_wr4c_wrap", d);
      txn(1'b1, 1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 1, "l1_rd0c", d);
      chk("l1_rd0c_data", {d[31:24], 24'h0}, 32'h99000000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
